hazard_unit: RTL
================

# hazard_unit

Pipeline control for the five-stage MIPS core: generates the per-latch enable and flush strobes consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC register. Detects load-use hazards, applies branch/jump redirect flushes, freezes the pipe on data-memory waits, and holds the core once a halt reaches MEM. Sits in the datapath beside the latches and is driven by decode, EX and memory-stage status.

## Interface
- No parameters; widths come from `cpu_types_pkg` (regbits_t = 5 bits).
- CLK  in  1  core clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete; may be a one-cycle pulse.
- mem_dREN, mem_dWEN  in  1 each  load/store in MEM.
- ex_dREN  in  1  instruction in EX is a load.
- ex_wsel  in  5  destination register of EX instruction.
- id_rs, id_rt  in  5 each  source registers of ID instruction.
- id_uses_rt  in  1  ID instruction reads rt.
- jump_id  in  1  jump (J/JAL/JR) decoded in ID.
- branch_taken  in  1  branch resolved taken in EX.
- halt_mem  in  1  halt instruction in MEM.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC load enables.
- ifid_flush, idex_flush  out  1 each  load bubble instead of data.
- halted  out  1  registered; core stopped.
- stall_cnt, flush_cnt  out  32 each  present only with HAZARD_PERF_EN.

## Operation
- Registers: state {RUN, MEMWAIT, HALT}, dhit_seen, flush_pend, halted.
- memstall = (mem_dREN|mem_dWEN) & !(dhit|dhit_seen).
- adv = ihit & !memstall & (state != HALT).
- lu = ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- redirect = branch_taken | flush_pend.
- pc_en = ifid_en = adv & !(lu & !redirect).
- ifid_flush = adv & (redirect | (jump_id & !lu)); load-use beats jump (JR operand dependency).
- idex_en = exmem_en = memwb_en = adv; idex_flush = adv & (redirect | lu).
- Redirect beats load-use: the dependent instruction is squashed anyway.
- flush_pend: set when branch_taken & !adv; cleared on adv.
- dhit_seen: set when dhit & !adv; cleared on adv.
- FSM transitions:
  - RUN -> MEMWAIT when memstall.
  - MEMWAIT -> RUN on adv.
  - RUN or MEMWAIT -> HALT when halt_mem & adv.
  - HALT is terminal until reset.
- HALT: all enables and flushes 0, halted = 1.

## Timing
- Enables and flushes are combinational from inputs and registered state; they are sampled by latches on the same CLK edge.
- halted rises on the edge after the cycle with halt_mem & adv.
- Load-use costs exactly one bubble: the following cycle the load is in MEM and lu drops.
- Branch redirect costs two bubbles (IF/ID and ID/EX flushed on one advancing edge). A jump costs one bubble.
- A dhit pulse arriving while ihit=0 is retained in dhit_seen and the access completes on the next ihit.
- Reset: state=RUN, flush_pend=0, dhit_seen=0, halted=0, counters=0. While nRST=0, all enables and flushes are forced 0.
- Reset mid-stall or mid-halt returns to RUN immediately; any pending flush is discarded.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle with state!=HALT & (!adv | (lu & !redirect)).
  - flush_cnt increments each cycle with ifid_flush | idex_flush.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- HAZARD_PERF_EN undefined: counters and ports are absent; all other behaviour is identical.

## Test plan
- Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; next cycle all enables=1, no flushes.
- ex_wsel=0 with id_rs=0 and ex_dREN=1 -> no stall; pc_en=1, idex_flush=0.
- Branch during ihit=0: branch_taken=1 for one cycle with ihit=0, then ihit=1 with branch_taken=0 -> ifid_flush=1 and idex_flush=1 on the ihit cycle; flush_pend clears afterwards.
- Memory wait: mem_dREN=1, dhit=0 for 3 cycles -> all enables 0 for 3 cycles (state MEMWAIT). dhit pulses while ihit=0, then ihit=1 -> all enables=1 on the ihit cycle.
- Halt: halt_mem=1, ihit=1 -> halted=1 the next cycle; all enables stay 0 for 10 further cycles. nRST pulse -> halted=0.
- With HAZARD_PERF_EN: one load-use stall plus one taken branch -> stall_cnt=1, flush_cnt=2.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline control for the five-stage MIPS core.
//
// Generates the PC / latch load enables and the IF/ID, ID/EX bubble strobes.
// Handles load-use stalls, branch/jump redirect flushes, data-memory waits and
// a terminal halt once a halt instruction reaches MEM.
//
// Ports:
//   CLK, nRST                     core clock (rising edge), async active-low reset
//   ihit, dhit                    fetch complete / data access complete (dhit may pulse)
//   mem_dREN, mem_dWEN            load/store in MEM
//   ex_dREN, ex_wsel              load in EX and its destination register
//   id_rs, id_rt, id_uses_rt      source registers of the ID instruction
//   jump_id, branch_taken         jump in ID, taken branch resolved in EX
//   halt_mem                      halt instruction in MEM
//   pc_en, ifid_en, idex_en,
//   exmem_en, memwb_en            PC / latch load enables
//   ifid_flush, idex_flush        load a bubble instead of data
//   halted                        registered, core stopped
//   stall_cnt, flush_cnt          performance counters (only with HAZARD_PERF_EN)
//
// Build option: define HAZARD_PERF_EN to add the stall/flush counters.

module hazard_unit (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       mem_dREN,
    input  logic       mem_dWEN,
    input  logic       ex_dREN,
    input  logic [4:0] ex_wsel,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       jump_id,
    input  logic       branch_taken,
    input  logic       halt_mem,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exmem_en,
    output logic       memwb_en,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       halted
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_t;

    state_t state;
    logic   dhit_seen;
    logic   flush_pend;

    logic memstall;
    logic adv;
    logic lu;
    logic redirect;

    always_comb begin
        // A dhit that arrived while the pipe could not advance still counts.
        memstall = (mem_dREN | mem_dWEN) & ~(dhit | dhit_seen);
        // Gating with nRST forces every enable and flush low during reset.
        adv      = nRST & ihit & ~memstall & (state != StHalt);
        lu       = ex_dREN & (ex_wsel != 5'd0) &
                   ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
        // A branch seen while frozen is applied on the next advancing edge.
        redirect = branch_taken | flush_pend;

        // Redirect beats load-use: the dependent instruction is squashed anyway.
        pc_en      = adv & ~(lu & ~redirect);
        ifid_en    = pc_en;
        // Load-use beats jump so a JR waits for its loaded operand.
        ifid_flush = adv & (redirect | (jump_id & ~lu));
        idex_en    = adv;
        exmem_en   = adv;
        memwb_en   = adv;
        idex_flush = adv & (redirect | lu);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= StRun;
            dhit_seen  <= 1'b0;
            flush_pend <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (adv) begin
                dhit_seen  <= 1'b0;
                flush_pend <= 1'b0;
            end else begin
                if (dhit)         dhit_seen  <= 1'b1;
                if (branch_taken) flush_pend <= 1'b1;
            end

            unique case (state)
                StRun: begin
                    if (halt_mem & adv) begin
                        state  <= StHalt;
                        halted <= 1'b1;
                    end else if (memstall) begin
                        state <= StMemWait;
                    end
                end
                StMemWait: begin
                    if (halt_mem & adv) begin
                        state  <= StHalt;
                        halted <= 1'b1;
                    end else if (adv) begin
                        state <= StRun;
                    end
                end
                StHalt: begin
                    state  <= StHalt;
                    halted <= 1'b1;
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if ((state != StHalt) & (~adv | (lu & ~redirect))) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ifid_flush | idex_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
